// File: rtl/sw_demux7_capture.sv
// 1-to-N demultiplexing capture register: a serial bit is steered into one of N_SLOTS
// registered slots, either by addressed write or as an auto-addressed frame.
module sw_demux7_capture #(
  parameter int unsigned N_SLOTS = 7,
  parameter int unsigned SEL_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               bit_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               wr,
  input  logic               start,
  output logic [N_SLOTS-1:0] out_bits,
  output logic               busy,
  output logic               done,
  output logic               bad_sel
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StCapture = 1'b1;

  localparam logic [SEL_W:0]   NumSlots = (SEL_W + 1)'(N_SLOTS);
  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(N_SLOTS - 1);

  logic [0:0]         state_q, state_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;
  logic [N_SLOTS-1:0] out_q, out_d;
  logic               done_q, done_d;
  logic               bad_q, bad_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start wins over a simultaneous wr; the wr is dropped without flagging.
        if (start) begin
          cnt_d   = '0;
          state_d = StCapture;
        end else if (wr) begin
          if ({1'b0, sel} < NumSlots) begin
            out_d[sel] = bit_in;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      StCapture: begin
        out_d[cnt_q] = bit_in;
        if (cnt_q == LastSlot) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
    end
  end

  assign out_bits = out_q;
  assign busy     = (state_q == StCapture);
  assign done     = done_q;
  assign bad_sel  = bad_q;

endmodule

// File: tb/tb_sw_demux7_capture.sv
// Self-checking bench for sw_demux7_capture: directed scenarios plus randomized traffic
// compared against a slot-level behavioural model.
module tb_sw_demux7_capture;

  logic       clock;
  logic       reset;
  logic       bit_in;
  logic [2:0] sel;
  logic       wr;
  logic       start;
  logic [6:0] out_bits;
  logic       busy;
  logic       done;
  logic       bad_sel;

  int unsigned n_vec;
  int unsigned n_bad;

  // Model: slot contents, position within a frame (-1 when idle), and expected pulses.
  logic [6:0] m_out;
  int         m_pos;
  logic       m_done;
  logic       m_bad;

  sw_demux7_capture #(
    .N_SLOTS(7),
    .SEL_W  (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bit_in  (bit_in),
    .sel     (sel),
    .wr      (wr),
    .start   (start),
    .out_bits(out_bits),
    .busy    (busy),
    .done    (done),
    .bad_sel (bad_sel)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic s, input logic w, input logic [2:0] sl,
                            input logic b);
    m_done = 1'b0;
    m_bad  = 1'b0;
    if (m_pos < 0) begin
      if (s) begin
        m_pos = 0;
      end else if (w) begin
        if (int'(sl) < 7) m_out[sl] = b;
        else m_bad = 1'b1;
      end
    end else begin
      m_out[m_pos] = b;
      m_pos++;
      if (m_pos == 7) begin
        m_pos  = -1;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("out_bits", 32'(out_bits), 32'(m_out));
    check("busy", 32'(busy), 32'(m_pos >= 0));
    check("done", 32'(done), 32'(m_done));
    check("bad_sel", 32'(bad_sel), 32'(m_bad));
  endtask

  // Called at a falling edge; applies inputs for one clock and checks at the next falling edge.
  task automatic cycle(input logic s, input logic w, input logic [2:0] sl, input logic b);
    start  = s;
    wr     = w;
    sel    = sl;
    bit_in = b;
    @(posedge clock);
    model_step(s, w, sl, b);
    @(negedge clock);
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next rising edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    m_out  = '0;
    m_pos  = -1;
    m_done = 1'b0;
    m_bad  = 1'b0;
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bad_sel", 32'(bad_sel), 32'd0);
    start = 1'b0;
    wr    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] frame_a;
    logic [6:0] frame_b;
    n_vec  = 0;
    n_bad  = 0;
    m_out  = '0;
    m_pos  = -1;
    m_done = 1'b0;
    m_bad  = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    wr     = 1'b0;
    sel    = '0;
    bit_in = 1'b0;
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b0;

    // Dirty the slots, then reset mid-cycle.
    cycle(1'b0, 1'b1, 3'd1, 1'b1);
    cycle(1'b0, 1'b1, 3'd5, 1'b1);
    do_reset();

    // Addressed writes to slots 0, 3, 6.
    cycle(1'b0, 1'b1, 3'd0, 1'b1);
    cycle(1'b0, 1'b1, 3'd3, 1'b1);
    cycle(1'b0, 1'b1, 3'd6, 1'b1);
    check("addr_word", 32'(out_bits), 32'h49);

    // Invalid select: pulse for exactly one cycle, slots untouched.
    cycle(1'b0, 1'b1, 3'd7, 1'b1);
    check("bad_pulse_hi", 32'(bad_sel), 32'd1);
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    check("bad_pulse_lo", 32'(bad_sel), 32'd0);
    check("bad_word", 32'(out_bits), 32'h49);

    // Frame 1,0,1,1,0,0,1 with a wr attempted while busy.
    frame_a = 7'b1001101;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, (i == 2), 3'd4, frame_a[i]);
    check("frame_word", 32'(out_bits), 32'h4d);
    check("frame_done", 32'(done), 32'd1);

    // start+wr together: frame wins, slot 2 gets the frame bit; back-to-back start on done.
    frame_b = 7'b0000000;
    cycle(1'b1, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 3'd0, frame_b[i]);
    check("prio_word", 32'(out_bits), 32'h00);
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 3'd0, frame_a[i]);
    check("b2b_word", 32'(out_bits), 32'h4d);

    // Abort on the 4th frame bit, then a clean frame.
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'd0, 1'b1);
    bit_in = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 3'd0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 3'd0, frame_a[i]);
    check("post_abort_word", 32'(out_bits), 32'h4d);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
